// File: rtl/spm_job_sequencer.sv
// Job sequencer for the SPM multiplier: queues operand pairs, drives SPM start/done,
// and returns each product (or a timeout marker) on a valid/ready result port.
module spm_job_sequencer #(
    parameter int unsigned W       = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_mp,
    input  logic [W-1:0]   in_mc,
    output logic           spm_start,
    output logic [W-1:0]   spm_mp,
    output logic [W-1:0]   spm_mc,
    input  logic           spm_done,
    input  logic [2*W-1:0] spm_p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_p,
    output logic           out_timeout,
    output logic           busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_OUT
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [W-1:0]   r_mem_mp [DEPTH];
    logic [W-1:0]   r_mem_mc [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [TW-1:0]  r_timer;
    logic [W-1:0]   r_spm_mp;
    logic [W-1:0]   r_spm_mc;
    logic [2*W-1:0] r_out_p;
    logic           r_out_timeout;

    logic           w_push;
    logic           w_pop;
    logic           w_nonempty;
    logic           w_capture;
    logic           w_abort;

    assign w_nonempty  = (r_count != '0);
    assign in_ready    = (r_count != C_FULL);
    assign w_push      = in_valid && in_ready;

    assign spm_start   = (r_state == S_START);
    assign out_valid   = (r_state == S_OUT);
    assign spm_mp      = r_spm_mp;
    assign spm_mc      = r_spm_mc;
    assign out_p       = r_out_p;
    assign out_timeout = r_out_timeout;
    assign busy        = (r_state != S_IDLE) || w_nonempty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_nonempty) begin
                    w_next = S_START;
                    w_pop  = 1'b1;
                end
            end
            S_START: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                // timer==0 on the first WAIT cycle masks a done left over from the previous job
                if (spm_done && (r_timer != '0)) begin
                    w_next    = S_OUT;
                    w_capture = 1'b1;
                end else if (r_timer == T_MAX) begin
                    w_next  = S_OUT;
                    w_abort = 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (w_nonempty) begin
                        w_next = S_START;
                        w_pop  = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_mp[r_wr_ptr] <= in_mp;
            r_mem_mc[r_wr_ptr] <= in_mc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_timer       <= '0;
            r_spm_mp      <= '0;
            r_spm_mc      <= '0;
            r_out_p       <= '0;
            r_out_timeout <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_spm_mp <= r_mem_mp[r_rd_ptr];
                r_spm_mc <= r_mem_mc[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (r_state == S_START) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT) begin
                r_timer <= r_timer + TW'(1);
            end

            if (w_capture) begin
                r_out_p       <= spm_p;
                r_out_timeout <= 1'b0;
            end else if (w_abort) begin
                r_out_p       <= '0;
                r_out_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spm_job_sequencer.sv
// Scoreboard bench for spm_job_sequencer with a behavioural SPM responder.
module tb_spm_job_sequencer;

    localparam int unsigned W  = 32;
    localparam int unsigned TO = 255;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_mp;
    logic [W-1:0]   in_mc;
    logic           spm_start;
    logic [W-1:0]   spm_mp;
    logic [W-1:0]   spm_mc;
    logic           spm_done;
    logic [2*W-1:0] spm_p;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic           out_timeout;
    logic           busy;

    spm_job_sequencer #(.W(W), .DEPTH(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mp(in_mp), .in_mc(in_mc),
        .spm_start(spm_start), .spm_mp(spm_mp), .spm_mc(spm_mc),
        .spm_done(spm_done), .spm_p(spm_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .out_timeout(out_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [63:0] p; logic to; } res_t;
    typedef struct packed { logic [31:0] mp; logic [31:0] mc; } op_t;
    res_t exp_q[$];
    op_t  op_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_starts = 0;

    int spm_lat   = 3;
    bit spm_dead  = 1'b0;
    bit spm_stale = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // SPM responder: one-cycle done pulse spm_lat cycles after the start pulse
    initial begin
        int cnt;
        cnt = 0;
        spm_done = 1'b0;
        spm_p = '0;
        forever begin
            @(posedge clk);
            #2;
            spm_done = spm_stale;
            if (rst) begin
                cnt = 0;
            end else if (spm_start) begin
                cnt = spm_lat;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !spm_dead) begin
                    spm_done = 1'b1;
                    spm_p = {32'b0, spm_mp} * {32'b0, spm_mc};
                end
            end
        end
    end

    // Monitor: result scoreboard, operand scoreboard, operand stability
    initial begin
        res_t e;
        op_t  o;
        bit   track;
        logic [31:0] cur_mp, cur_mc;
        track = 1'b0;
        cur_mp = '0;
        cur_mc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                track = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", {63'b0, out_valid}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_p", out_p, e.p);
                        check("out_timeout", {63'b0, out_timeout}, {63'b0, e.to});
                    end
                end
                if (spm_start) begin
                    n_starts++;
                    if (op_q.size() == 0) begin
                        check("unexpected_start", {63'b0, spm_start}, 64'd0);
                    end else begin
                        o = op_q.pop_front();
                        check("spm_mp", {32'b0, spm_mp}, {32'b0, o.mp});
                        check("spm_mc", {32'b0, spm_mc}, {32'b0, o.mc});
                    end
                    cur_mp = spm_mp;
                    cur_mc = spm_mc;
                    track = 1'b1;
                end else if (track) begin
                    check("mp_stable", {32'b0, spm_mp}, {32'b0, cur_mp});
                    check("mc_stable", {32'b0, spm_mc}, {32'b0, cur_mc});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] mp, input logic [31:0] mc,
                        input logic [63:0] p, input logic to);
        int k;
        in_valid = 1'b1;
        in_mp = mp;
        in_mc = mc;
        for (k = 0; k < 2000; k++) begin
            if (in_ready) break;
            tick();
        end
        if (!in_ready) begin
            check("push_accept_timeout", {63'b0, in_ready}, 64'd1);
        end else begin
            exp_q.push_back('{p: p, to: to});
            op_q.push_back('{mp: mp, mc: mc});
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy && !out_valid && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},    {63'b0, in_ready},    64'd1);
        check({tag, "_spm_start"},   {63'b0, spm_start},   64'd0);
        check({tag, "_spm_mp"},      {32'b0, spm_mp},      64'd0);
        check({tag, "_spm_mc"},      {32'b0, spm_mc},      64'd0);
        check({tag, "_out_valid"},   {63'b0, out_valid},   64'd0);
        check({tag, "_out_p"},       out_p,                64'd0);
        check({tag, "_out_timeout"}, {63'b0, out_timeout}, 64'd0);
        check({tag, "_busy"},        {63'b0, busy},        64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        bit seen;
        rst = 1'b1;
        in_valid = 1'b0;
        in_mp = '0;
        in_mc = '0;
        out_ready = 1'b1;

        tick();
        tick();
        @(negedge clk);
        check_reset_vals("reset");
        tick();
        rst = 1'b0;

        // single job
        s0 = n_starts;
        push(32'd2, 32'd3, 64'd6, 1'b0);
        wait_idle();
        check("single_start_pulses", 64'(n_starts - s0), 64'd1);

        // width corner
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
        wait_idle();

        // burst: FIFO fills behind the job in flight
        push(32'd1, 32'd1, 64'd1, 1'b0);
        push(32'd2, 32'd2, 64'd4, 1'b0);
        push(32'd3, 32'd3, 64'd9, 1'b0);
        push(32'd4, 32'd4, 64'd16, 1'b0);
        push(32'd5, 32'd5, 64'd25, 1'b0);
        @(negedge clk);
        check("burst_full_in_ready", {63'b0, in_ready}, 64'd0);
        check("burst_busy", {63'b0, busy}, 64'd1);
        wait_idle();

        // backpressure
        out_ready = 1'b0;
        push(32'd7, 32'd8, 64'd56, 1'b0);
        push(32'd9, 32'd10, 64'd90, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_out_valid_seen", {63'b0, seen}, 64'd1);
        s0 = n_starts;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("bp_out_p_hold", out_p, 64'd56);
            check("bp_out_valid_hold", {63'b0, out_valid}, 64'd1);
        end
        check("bp_no_new_start", 64'(n_starts - s0), 64'd0);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake_valid", {63'b0, out_valid}, 64'd1);
        @(negedge clk);
        check("bp_start_after_hs", {63'b0, spm_start}, 64'd1);
        wait_idle();

        // timeout: cycles strictly between the start pulse and out_valid
        spm_dead = 1'b1;
        push(32'd11, 32'd12, 64'd0, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (spm_start) begin
                seen = 1'b1;
                break;
            end
        end
        check("to_start_seen", {63'b0, seen}, 64'd1);
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        check("to_wait_cycles", 64'(n), 64'(TO + 1));
        check("to_flag", {63'b0, out_timeout}, 64'd1);
        wait_idle();
        spm_dead = 1'b0;
        push(32'd6, 32'd7, 64'd42, 1'b0);
        wait_idle();

        // reset mid-WAIT with two jobs queued, stale done held high afterwards
        spm_lat = 50;
        push(32'd3, 32'd5, 64'd15, 1'b0);
        push(32'd4, 32'd4, 64'd16, 1'b0);
        push(32'd5, 32'd5, 64'd25, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        exp_q.delete();
        op_q.delete();
        spm_stale = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stale_no_valid", {63'b0, out_valid}, 64'd0);
            check("stale_no_busy", {63'b0, busy}, 64'd0);
        end
        tick();
        spm_stale = 1'b0;
        spm_lat = 3;
        push(32'd8, 32'd9, 64'd72, 1'b0);
        wait_idle();

        check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("final_op_q_empty", 64'(op_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
